mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port (addr / we / data_write / data_read / data_valid) between N requesters, e.g. the load/store pipeline and instruction fetch.
- Round-robin arbitration with the grant locked until the memory acknowledges with mem_data_valid.
- Watchdog aborts transactions the memory never acknowledges.
- Sits between the requesting units and the memory interface at core top level.

Parameters:
N_PORTS, 2, number of requesters (2..8)
MAX_WAIT, 255, cycles in BUSY without mem_data_valid before abort (1..65535)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_i  in  N_PORTS  per-port request, held until that port's resp_valid_o
addr_i  in  [N_PORTS][32]  per-port byte address
we_i  in  [N_PORTS][4]  per-port byte write enables; 0 means load
wdata_i  in  [N_PORTS][32]  per-port store data
resp_valid_o  out  N_PORTS  one-cycle completion pulse to granted port
resp_err_o  out  N_PORTS  one-cycle abort pulse, coincident with resp_valid_o
resp_data_o  out  32  read data, broadcast; valid only with resp_valid_o and no error
gnt_o  out  N_PORTS  one-hot current owner; 0 when idle
mem_req  out  1  transaction active toward memory
mem_addr  out  32  registered address
mem_we  out  4  registered write enables
mem_data_write  out  32  registered store data
mem_data_read  in  32  memory read data
mem_data_valid  in  1  memory completion (load data or store ack)

Behaviour:
- Reset (reset==0 at posedge):
  - state IDLE; mem_req, mem_addr, mem_we, mem_data_write = 0.
  - gnt_o = 0; wait counter = 0.
  - priority pointer set so port 0 has highest priority.
  - Any in-flight transaction is dropped: no resp pulse is issued.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If any req_i is set, pick the winner round-robin: search starts at last_grant+1 and wraps modulo N_PORTS.
  - At the next edge: latch the winner's addr/we/wdata into mem_*, set gnt_o one-hot, set mem_req=1, enter BUSY.
  - Latency: req_i high in cycle t gives mem_req high in cycle t+1.
- BUSY:
  - mem_* and gnt_o are held stable; the wait counter increments each cycle.
- Completion (mem_data_valid==1 in BUSY):
  - Combinational: resp_valid_o[g]=1 and resp_data_o=mem_data_read in that same cycle.
  - last_grant is updated to g.
  - Re-arbitration happens in the same cycle with port g masked out, because its req_i is still high this cycle.
  - If another request is pending: stay BUSY, load the new winner, mem_req stays 1. Back-to-back throughput is one transaction per memory ack.
  - Otherwise: go to IDLE; mem_req=0 and gnt_o=0 next cycle.
- Timeout:
  - If the counter reaches MAX_WAIT with no mem_data_valid, pulse resp_valid_o[g] and resp_err_o[g]; resp_data_o=0.
  - Then re-arbitrate exactly as for a normal completion.
  - A mem_data_valid arriving in the same cycle as the timeout wins: normal completion, no error.
- Stores use the same handshake; mem_data_read is ignored but still forwarded.
- mem_data_valid while IDLE is ignored: no pulses, no state change.
- A req_i dropped by a non-granted requester before grant is legal. Dropping req_i while granted is illegal; the transaction still completes and the pulse is still issued.
- Counter width is $clog2(MAX_WAIT+1); it clears on every new grant.
- resp_valid_o is never asserted for more than one port in any cycle.

Decomposition:
- Shared package:
  - MEM_REQ struct {addr[31:0], we[3:0], wdata[31:0]}.
  - Typedef for arbiter state.
  - Constant MEM_WAIT_DEFAULT=255.
- Sub-module rr_arbiter: combinational round-robin picker.
  - Inputs: req, mask, last_grant.
  - Outputs: one-hot grant, any.
  - Parameterised by N_PORTS; reused by the result-bus arbiter.

Test Plan:
1. Port0 load addr 0x100, memory returns 0xDEADBEEF after 3 cycles -> mem_req rises 1 cycle after req, mem_addr=0x100, mem_we=0; resp_valid_o=01 and resp_data_o=0xDEADBEEF in the ack cycle; gnt_o=0 the cycle after.
2. Both ports request continuously, memory acks every 2 cycles -> grants alternate 01,10,01,10; mem_req never drops; each port gets one resp per two acks.
3. Port1 store we=1111 wdata=0x12345678 addr 0x200 -> mem_we=1111 and mem_data_write=0x12345678 held stable every BUSY cycle until ack; resp_err_o=0.
4. MAX_WAIT=4, memory never acks -> resp_valid_o and resp_err_o pulse on the granted port after 4 BUSY cycles; FSM re-arbitrates. Repeat with ack landing in the timeout cycle -> no error.
5. Reset asserted mid-BUSY -> next cycle mem_req=0, gnt_o=0, no resp pulse; a later ack while IDLE is ignored; the first request after reset from both ports goes to port 0.
6. mem_data_valid pulse while IDLE, no requests -> all outputs stay 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
//   mem_req_t        : one latched memory transaction (address, byte enables, store data)
//   arb_state_t      : arbiter FSM state
//   MEM_WAIT_DEFAULT : default watchdog limit in BUSY cycles
package mem_port_arbiter_pkg;

   localparam int MEM_WAIT_DEFAULT = 255;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
   } mem_req_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req        : per-port request vector
//   mask       : ports allowed to compete this cycle (1 = eligible)
//   last_grant : index of the most recently served port; search starts one above it
//   grant      : one-hot winner, all zero when nothing eligible
//   any        : at least one eligible request
module rr_arbiter #(
   parameter int N_PORTS = 2,
   parameter int LG_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
   input  logic [N_PORTS-1:0] req,
   input  logic [N_PORTS-1:0] mask,
   input  logic [LG_W-1:0]    last_grant,
   output logic [N_PORTS-1:0] grant,
   output logic               any
);

   logic [N_PORTS-1:0] eligible;
   logic [LG_W-1:0]    idx;

   always_comb begin
      grant    = '0;
      any      = 1'b0;
      idx      = '0;
      eligible = req & mask;
      // i = N_PORTS wraps back to last_grant itself, so it has lowest priority
      for (int i = 1; i <= N_PORTS; i++) begin
         idx = LG_W'((int'(last_grant) + i) % N_PORTS);
         if (!any && eligible[idx]) begin
            grant[idx] = 1'b1;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between N_PORTS requesters.
// Round-robin grant, locked until mem_data_valid; a watchdog aborts a
// transaction after MAX_WAIT unacknowledged BUSY cycles.
//   clk, reset        : clock, synchronous active-low reset
//   req_i/addr_i/we_i/wdata_i : per-port request and payload
//   resp_valid_o/resp_err_o/resp_data_o : completion pulse, abort flag, read data
//   gnt_o             : one-hot current owner
//   mem_req/mem_addr/mem_we/mem_data_write : registered memory request
//   mem_data_read/mem_data_valid           : memory response
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | no transaction; arbitrate any pending request
// ST_BUSY | transaction owned by gnt_o, waiting for ack or timeout
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int N_PORTS  = 2,
   parameter int MAX_WAIT = MEM_WAIT_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_PORTS-1:0]       req_i,
   input  logic [N_PORTS-1:0][31:0] addr_i,
   input  logic [N_PORTS-1:0][3:0]  we_i,
   input  logic [N_PORTS-1:0][31:0] wdata_i,
   output logic [N_PORTS-1:0]       resp_valid_o,
   output logic [N_PORTS-1:0]       resp_err_o,
   output logic [31:0]              resp_data_o,
   output logic [N_PORTS-1:0]       gnt_o,
   output logic                     mem_req,
   output logic [31:0]              mem_addr,
   output logic [3:0]               mem_we,
   output logic [31:0]              mem_data_write,
   input  logic [31:0]              mem_data_read,
   input  logic                     mem_data_valid
);

   localparam int LG_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int CW   = $clog2(MAX_WAIT + 1);

   arb_state_t         state_q, state_d;
   logic [N_PORTS-1:0] gnt_q;
   logic [LG_W-1:0]    last_q;
   logic [LG_W-1:0]    gnt_idx;
   logic [CW-1:0]      cnt_q;
   mem_req_t           mem_q;
   mem_req_t           win;

   logic               busy;
   logic               complete;
   logic               timeout;
   logic               done;
   logic               load;
   logic [N_PORTS-1:0] arb_mask;
   logic [LG_W-1:0]    arb_last;
   logic [N_PORTS-1:0] arb_grant;
   logic               arb_any;

   assign busy     = (state_q == ST_BUSY);
   assign complete = busy && mem_data_valid;
   // an ack in the timeout cycle wins over the abort
   assign timeout  = busy && !mem_data_valid && (cnt_q == CW'(MAX_WAIT));
   assign done     = complete || timeout;

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (gnt_q[i]) gnt_idx = LG_W'(i);
      end
   end

   // On completion the owner's req_i is still high, so mask it out and
   // search from it as if last_grant were already updated.
   assign arb_mask = busy ? ~gnt_q : '1;
   assign arb_last = busy ? gnt_idx : last_q;

   rr_arbiter #(
      .N_PORTS (N_PORTS),
      .LG_W    (LG_W)
   ) u_rr (
      .req        (req_i),
      .mask       (arb_mask),
      .last_grant (arb_last),
      .grant      (arb_grant),
      .any        (arb_any)
   );

   always_comb begin
      win = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (arb_grant[i]) begin
            win.addr  = addr_i[i];
            win.we    = we_i[i];
            win.wdata = wdata_i[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               load    = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (done) begin
               if (arb_any) load = 1'b1;
               else         state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         last_q  <= LG_W'(N_PORTS - 1);
         cnt_q   <= '0;
         mem_q   <= '0;
      end else begin
         state_q <= state_d;
         if (done) last_q <= gnt_idx;
         if (load) begin
            mem_q <= win;
            gnt_q <= arb_grant;
            cnt_q <= '0;
         end else if (done) begin
            gnt_q <= '0;
         end else if (busy) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   // Pulses are suppressed while reset is asserted so an in-flight
   // transaction is dropped silently.
   always_comb begin
      resp_valid_o = '0;
      resp_err_o   = '0;
      resp_data_o  = '0;
      if (reset && done) resp_valid_o = gnt_q;
      if (reset && timeout) resp_err_o = gnt_q;
      if (reset && complete) resp_data_o = mem_data_read;
   end

   assign gnt_o          = gnt_q;
   assign mem_req        = busy;
   assign mem_addr       = mem_q.addr;
   assign mem_we         = mem_q.we;
   assign mem_data_write = mem_q.wdata;

endmodule
